systolic_seq_ctrl: RTL

Parametrised sequencer for an N_PE-wide systolic array. It replaces the fixed 4-PE, fixed-length controller. It adds:
- a start/busy/done handshake,
- a runtime vector length,
- weight/bias reuse modes,
- input-valid stalling and output backpressure during drain.

It drives the array's per-PE enables and drain select; the datapath is unchanged.

---
 rtl/systolic_seq_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: pass sequencer for an N_PE-wide systolic array.
// Walks LOAD_W -> LOAD_B -> COMPUTE -> DRAIN -> DONE for each accepted start.
// All array controls decode combinationally from the registered state and cnt,
// so an asynchronous reset forces every output to 0 without waiting for a clock.
module systolic_seq_ctrl #(
  parameter int N_PE = 4,
  parameter int MAX_K = 16,
  localparam int CW = $clog2(MAX_K + 1),
  localparam int SW = $clog2(N_PE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CW-1:0]   vec_len,
  input  logic            keep_w,
  input  logic            keep_b,
  input  logic            in_valid,
  input  logic            out_ready,
  output logic [N_PE-1:0] pe_weight_en,
  output logic [N_PE-1:0] pe_bias_en,
  output logic [N_PE-1:0] pe_acc_en,
  output logic [SW-1:0]   drain_sel,
  output logic            out_valid,
  output logic            busy,
  output logic            done
);

  // cnt must reach K+N_PE-2 during COMPUTE, the largest value it ever holds
  localparam int CNTW = $clog2(MAX_K + N_PE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_B,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [CW-1:0]   k_len;
  logic            skip_b;
  logic            w_loaded;
  logic            b_loaded;

  logic            len_ok;
  logic            use_w;
  logic            use_b;
  logic            load_last;
  logic            compute_last;
  logic            drain_last;

  // A start is legal only for 1..MAX_K vectors; reuse is only honoured when
  // the corresponding registers were actually loaded since the last reset.
  assign len_ok       = (vec_len != '0) && (int'(vec_len) <= MAX_K);
  assign use_w        = keep_w && w_loaded;
  assign use_b        = keep_b && b_loaded;
  assign load_last    = (cnt == CNTW'(N_PE - 1));
  assign compute_last = (int'(cnt) == int'(k_len) + N_PE - 2);
  assign drain_last   = (cnt == CNTW'(N_PE - 1));

  // Sequencer: state, counter, captured pass parameters and loaded flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      k_len    <= '0;
      skip_b   <= 1'b0;
      w_loaded <= 1'b0;
      b_loaded <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && len_ok) begin
            k_len  <= vec_len;
            // bias skip decision is frozen now so a later LOAD_W cannot change it
            skip_b <= use_b;
            cnt    <= '0;
            if (!use_w) begin
              state <= S_LOAD_W;
            end else if (!use_b) begin
              state <= S_LOAD_B;
            end else begin
              state <= S_COMPUTE;
            end
          end
        end

        S_LOAD_W: begin
          if (in_valid) begin
            if (load_last) begin
              w_loaded <= 1'b1;
              cnt      <= '0;
              state    <= skip_b ? S_COMPUTE : S_LOAD_B;
            end else begin
              cnt <= cnt + CNTW'(1);
            end
          end
        end

        S_LOAD_B: begin
          if (in_valid) begin
            if (load_last) begin
              b_loaded <= 1'b1;
              cnt      <= '0;
              state    <= S_COMPUTE;
            end else begin
              cnt <= cnt + CNTW'(1);
            end
          end
        end

        S_COMPUTE: begin
          if (in_valid) begin
            if (compute_last) begin
              cnt   <= '0;
              state <= S_DRAIN;
            end else begin
              cnt <= cnt + CNTW'(1);
            end
          end
        end

        S_DRAIN: begin
          if (out_ready) begin
            if (drain_last) begin
              cnt   <= '0;
              state <= S_DONE;
            end else begin
              cnt <= cnt + CNTW'(1);
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Per-PE strobes: one-hot loads follow cnt, accumulate enables form the
  // diagonal wavefront where PE i is active for feed steps i..i+K-1.
  for (genvar gi = 0; gi < N_PE; gi++) begin : gen_pe
    assign pe_weight_en[gi] = (state == S_LOAD_W) && in_valid && (int'(cnt) == gi);
    assign pe_bias_en[gi]   = (state == S_LOAD_B) && in_valid && (int'(cnt) == gi);
    assign pe_acc_en[gi]    = (state == S_COMPUTE) && in_valid &&
                              (int'(cnt) >= gi) && (int'(cnt) < gi + int'(k_len));
  end

  // Drain and handshake outputs, all zero outside their owning states
  always_comb begin
    drain_sel = '0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_LOAD_W, S_LOAD_B, S_COMPUTE: begin
        busy = 1'b1;
      end
      S_DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        drain_sel = cnt[SW-1:0];
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule
